sram_mem_controller: RTL and testbench
======================================

// Module: sram_mem_controller
// PURPOSE
//  - MEM-stage responder to the MEM_R_EN/MEM_W_EN, address and store data produced by the ID-stage control unit.
//  - Services one 32-bit LDR/STR as two sequential 16-bit accesses to the external asynchronous SRAM.
//  - Holds ready low for the whole access; the hazard/freeze logic stalls the pipeline on ~ready.
// PARAMETERS
//  - ADDR_BASE    1024  byte address that maps to SRAM word 0
//  - WAIT_CYCLES  2     cycles each 16-bit half-access is held on the SRAM pins (>=1)
// PORTS
//  - clk         in     1   single clock, rising edge
//  - rst         in     1   asynchronous, active-low reset
//  - rd_en       in     1   MEM_R_EN from pipeline; held until ready
//  - wr_en       in     1   MEM_W_EN from pipeline; held until ready
//  - address     in     32  byte address (ALU result); bits [1:0] ignored
//  - write_data  in     32  store data
//  - read_data   out    32  load data; valid while ready=1 at end of a read
//  - ready       out    1   1 = no access pending or access completing this cycle
//  - SRAM_DQ     inout  16  SRAM data bus
//  - SRAM_ADDR   out    18  SRAM half-word address
//  - SRAM_WE_N   out    1   SRAM write enable, active low
// BEHAVIOUR
//  - Address: word = (address - ADDR_BASE) >> 2, truncated to 17 bits; SRAM_ADDR = {word, half}, half 0 = bits [15:0], half 1 = bits [31:16].
//  - FSM: IDLE -> LOW -> HIGH -> DONE -> IDLE.
//    - IDLE: leave on (rd_en | wr_en).
//    - LOW and HIGH: each held exactly WAIT_CYCLES cycles, using a wait counter reset on every state entry.
//    - DONE: lasts 1 cycle.
//  - ready = 1 in IDLE with no request, and in DONE; 0 otherwise (combinational).
//  - Latency: request visible in IDLE at cycle 0 -> ready=1 at cycle 2*WAIT_CYCLES+1. Pipeline advances on that edge.
//  - Back-to-back requests restart from IDLE, so the next access pays the full latency again.
//  - Write:
//    - SRAM_WE_N=0 throughout LOW and HIGH.
//    - SRAM_DQ drives write_data[15:0] in LOW and write_data[31:16] in HIGH.
//    - read_data is unchanged.
//  - Read:
//    - SRAM_WE_N=1 and SRAM_DQ=16'bz.
//    - SRAM_DQ is sampled on the last cycle of LOW into bits [15:0] and the last cycle of HIGH into bits [31:16].
//    - read_data is registered and updated on entry to DONE.
//  - Both rd_en and wr_en high: treated as a write.
//  - Request dropped before DONE: return to IDLE next cycle, SRAM_WE_N=1, read_data unchanged.
//  - Outside LOW/HIGH: SRAM_WE_N=1 and SRAM_DQ=16'bz. The bus is never driven during a read.
//  - Reset (asynchronous, also mid-access):
//    - state=IDLE, counter=0, read_data=0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ=16'bz, all immediately.
//    - ready=1 after reset when no request is present.
// CONFIGURATION
//  - SRAM_READ_BUFFER_EN defined:
//    - Adds a one-entry buffer {valid, word, data} loaded by every completed read.
//    - A read whose word matches a valid entry hits: ready=1 and read_data=buffer data in the same cycle; the FSM stays in IDLE and no SRAM access occurs.
//    - A write to a matching word updates the buffer data at DONE.
//    - The buffer is invalidated at reset.
//  - SRAM_READ_BUFFER_EN undefined: no buffer, and every read takes the full latency.
// TESTING (WAIT_CYCLES=2, ADDR_BASE=1024)
//  - No request after reset -> ready=1, SRAM_WE_N=1, SRAM_DQ=z, read_data=0.
//  - wr_en, address=1024, write_data=32'hDEADBEEF:
//    - SRAM_ADDR=0 / DQ=16'hBEEF for 2 cycles, then SRAM_ADDR=1 / DQ=16'hDEAD for 2 cycles, WE_N=0 for those 4 cycles.
//    - ready=1 at cycle 5.
//  - rd_en, address=1024 against an SRAM model holding the above -> ready=1 at cycle 5 with read_data=32'hDEADBEEF; DQ never driven.
//  - wr_en, address=1032 -> SRAM_ADDR=4 then 5; rd_en and wr_en both high -> write sequence, read_data unchanged.
//  - rst low during HIGH of a write -> SRAM_WE_N=1 and DQ=z immediately; ready=1 after release; next read is full length.
//  - SRAM_READ_BUFFER_EN: read 1024, then read 1024 again -> second read ready=1 at cycle 0 with 32'hDEADBEEF.
//    - Then write 32'h12345678 to 1024 and read it -> hit returns 32'h12345678.

Source files
------------

// File: rtl/sram_mem_controller.sv
// MEM-stage controller: one 32-bit load/store as two 16-bit accesses to an asynchronous SRAM.
// Optional one-entry read buffer enabled by defining SRAM_READ_BUFFER_EN.
module sram_mem_controller #(
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N
);

    localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [16:0]     word_q;
    logic            is_write_q;
    logic [15:0]     low_q;
    logic [31:0]     read_data_q;

    logic [31:0] offset;
    logic [16:0] req_word;
    logic        unused_offset;
    logic        req;
    logic        hit;
    logic        last_cycle;
    logic        start;
    logic        low_sample;
    logic        complete;
    logic        drive;
    logic [15:0] wdata_half;

    assign offset        = address - ADDR_BASE;
    assign req_word      = offset[18:2];
    assign unused_offset = ^{offset[31:19], offset[1:0]};
    assign req           = rd_en | wr_en;
    assign last_cycle    = (cnt_q == CntLast);

`ifdef SRAM_READ_BUFFER_EN
    logic        buf_valid_q;
    logic [16:0] buf_word_q;
    logic [31:0] buf_data_q;

    // A pure read (write has priority) to the buffered word completes without touching the SRAM.
    assign hit = (state_q == StIdle) && rd_en && !wr_en && buf_valid_q &&
                 (buf_word_q == req_word);
`else
    assign hit = 1'b0;
`endif

    assign start      = (state_q == StIdle) && req && !hit;
    assign low_sample = (state_q == StLow) && req && last_cycle;
    assign complete   = (state_q == StHigh) && req && last_cycle;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start) state_d = StLow;
            end
            StLow: begin
                if (!req) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (last_cycle) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHigh: begin
                if (!req) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (last_cycle) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            word_q      <= '0;
            is_write_q  <= 1'b0;
            low_q       <= '0;
            read_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start) begin
                word_q     <= req_word;
                is_write_q <= wr_en;
            end
            if (low_sample && !is_write_q) low_q <= SRAM_DQ;
            if (complete && !is_write_q) read_data_q <= {SRAM_DQ, low_q};
        end
    end

`ifdef SRAM_READ_BUFFER_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            buf_word_q  <= '0;
            buf_data_q  <= '0;
        end else if (complete) begin
            if (!is_write_q) begin
                buf_valid_q <= 1'b1;
                buf_word_q  <= word_q;
                buf_data_q  <= {SRAM_DQ, low_q};
            end else if (buf_valid_q && (buf_word_q == word_q)) begin
                buf_data_q <= write_data;
            end
        end
    end

    assign read_data = hit ? buf_data_q : read_data_q;
`else
    assign read_data = read_data_q;
`endif

    // Bus is only driven while a write is actually in progress; a dropped request releases it.
    assign drive      = (state_q == StLow || state_q == StHigh) && req && is_write_q;
    assign wdata_half = (state_q == StHigh) ? write_data[31:16] : write_data[15:0];
    assign SRAM_DQ    = drive ? wdata_half : 16'bz;
    assign SRAM_WE_N  = !drive;
    assign SRAM_ADDR  = {word_q, (state_q == StHigh)};
    assign ready      = ((state_q == StIdle) && (!req || hit)) || (state_q == StDone);

endmodule

// File: tb/tb_sram_mem_controller.sv
// Self-checking bench for sram_mem_controller: directed cases plus random loads/stores
// against a word-level reference memory; the SRAM data bus is pulled high when undriven.
module tb_sram_mem_controller;

    localparam int WAIT = 2;
    localparam int BASE = 1024;
    localparam int LAT  = 2 * WAIT + 1;
`ifdef SRAM_READ_BUFFER_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    tri1  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;

    sram_mem_controller #(
        .ADDR_BASE   (BASE),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_WE_N  (sram_we_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM device: half-word array, driven only when enabled by the bench.
    logic [15:0] dev [0:255];
    logic        sram_oe;
    assign sram_dq = (sram_oe && sram_we_n) ? dev[sram_addr[7:0]] : 16'bz;
    always @(posedge clk) if (!sram_we_n) dev[sram_addr[7:0]] <= sram_dq;

    // Reference model: 32-bit words, last SRAM-completed read, one-entry buffer.
    logic [31:0] ref_mem [0:127];
    logic [31:0] last_rd;
    bit          buf_v;
    int          buf_w;
    logic [31:0] buf_d;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called and returns at 1 time unit after a rising edge.
    task automatic access(input bit rd, input bit wr, input int word, input logic [31:0] wd,
                          input bit oe);
        bit          is_wr, hit, win;
        int          lat;
        logic [31:0] exp_rd;
        logic [17:0] ea;
        logic [15:0] ed;
        is_wr  = wr;
        hit    = BUF_EN && rd && !wr && buf_v && (buf_w == word);
        lat    = hit ? 0 : LAT;
        exp_rd = is_wr ? last_rd : (hit ? buf_d : (oe ? ref_mem[word] : 32'hFFFF_FFFF));
        address    = 32'(BASE + word * 4) + 32'($urandom_range(0, 3));
        rd_en      = rd;
        wr_en      = wr;
        write_data = wd;
        sram_oe    = oe;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            win = (k >= 1) && (k <= 2 * WAIT);
            chk("ready", 32'(ready), 32'(k == lat));
            chk("we_n", 32'(sram_we_n), 32'(!(is_wr && win)));
            if (win) begin
                ea = {word[16:0], (k > WAIT)};
                chk("sram_addr", 32'(sram_addr), 32'(ea));
                if (is_wr) begin
                    ed = (k > WAIT) ? wd[31:16] : wd[15:0];
                    chk("dq_write", 32'(sram_dq), 32'(ed));
                end
            end
            if (!oe && !(is_wr && win)) chk("dq_float", 32'(sram_dq), 32'h0000_FFFF);
            if (k == lat) chk("read_data", read_data, exp_rd);
            if (k < lat) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        sram_oe = 1'b0;
        if (is_wr) begin
            ref_mem[word] = wd;
            if (buf_v && buf_w == word) buf_d = wd;
        end else if (!hit) begin
            last_rd = exp_rd;
            buf_v   = 1'b1;
            buf_w   = word;
            buf_d   = exp_rd;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dev[i] = '0;
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;
        last_rd    = '0;
        buf_v      = 1'b0;
        buf_w      = 0;
        buf_d      = '0;
        rst        = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = '0;
        write_data = '0;
        sram_oe    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_dq", 32'(sram_dq), 32'h0000_FFFF);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_we_n", 32'(sram_we_n), 32'd1);
        @(posedge clk);
        #1;

        // Write, read back, re-read (hits when the buffer is present), update, read again.
        access(1'b0, 1'b1, 0, 32'hDEAD_BEEF, 1'b0);
        access(1'b1, 1'b0, 0, 32'h0000_0000, 1'b1);
        access(1'b1, 1'b0, 0, 32'h0000_0000, 1'b1);
        access(1'b0, 1'b1, 0, 32'h1234_5678, 1'b0);
        access(1'b1, 1'b0, 0, 32'h0000_0000, 1'b1);

        // Read with the SRAM not driving: the controller must leave the bus floating.
        access(1'b1, 1'b0, 20, 32'h0000_0000, 1'b0);

        // Address 1032 -> half-words 4/5; read+write together behaves as a write.
        access(1'b0, 1'b1, 2, 32'hA5A5_0F0F, 1'b0);
        access(1'b1, 1'b1, 2, 32'h1357_9BDF, 1'b0);
        access(1'b1, 1'b0, 2, 32'h0000_0000, 1'b1);

        // Read abandoned during LOW: back to idle, read_data untouched.
        address = 32'(BASE + 31 * 4);
        rd_en   = 1'b1;
        sram_oe = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rd_en   = 1'b0;
        sram_oe = 1'b0;
        @(negedge clk);
        chk("drop_busy", 32'(ready), 32'd0);
        chk("drop_we_n", 32'(sram_we_n), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("drop_ready", 32'(ready), 32'd1);
        chk("drop_rdata", read_data, last_rd);
        @(posedge clk);
        #1;

        // Reset asserted during the HIGH half of a write.
        address    = 32'(BASE + 10 * 4);
        write_data = 32'hCAFE_F00D;
        wr_en      = 1'b1;
        repeat (WAIT + 1) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_we_n", 32'(sram_we_n), 32'd0);
        chk("pre_rst_addr", 32'(sram_addr), 32'd21);
        rst = 1'b0;
        #1;
        chk("mid_rst_we_n", 32'(sram_we_n), 32'd1);
        chk("mid_rst_dq", 32'(sram_dq), 32'h0000_FFFF);
        chk("mid_rst_addr", 32'(sram_addr), 32'd0);
        chk("mid_rst_rdata", read_data, 32'd0);
        wr_en = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        last_rd = '0;
        buf_v   = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 0, 32'h0000_0000, 1'b1);
        access(1'b0, 1'b1, 10, 32'h0BAD_CAFE, 1'b0);
        access(1'b1, 1'b0, 10, 32'h0000_0000, 1'b1);

        // Random mix of loads, stores and combined requests over a small word range.
        for (int n = 0; n < 24; n++) begin
            int          op;
            int          w;
            logic [31:0] d;
            op = int'($urandom_range(0, 3));
            w  = int'($urandom_range(0, 15));
            d  = $urandom;
            case (op)
                0, 1:    access(1'b1, 1'b0, w, d, 1'b1);
                2:       access(1'b0, 1'b1, w, d, 1'b0);
                default: access(1'b1, 1'b1, w, d, 1'b0);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
